// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with flush, optional skid entry and saturating stall counter
module pipe_stage_reg #(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int SKID = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);
  logic             main_v, skid_v, accept;
  logic [WIDTH-1:0] main_d, skid_d;
  // with SKID=0 the skid entry can never load, since accept implies main is free or draining
  assign in_ready  = (SKID != 0) ? !skid_v : (!main_v || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = main_v;
  assign out_data  = main_d;
  assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= RESET_VAL;
      skid_d <= RESET_VAL;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (skid_v && out_ready) begin
      main_d <= skid_d;
      skid_v <= 1'b0;
    end else if (accept && (!main_v || out_ready)) begin
      main_v <= 1'b1;
      main_d <= in_data;
    end else if (accept) begin
      skid_v <= 1'b1;
      skid_d <= in_data;
    end else if (main_v && out_ready) begin
      main_v <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else if (main_v && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed and randomised checks of both skid modes
module tb_pipe_stage_reg;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rs1, fl1, iv1, ir1, ov1, or1;
  logic [7:0] id1, od1;
  logic [1:0] oc1;
  logic [2:0] sc1;
  logic       rs0, fl0, iv0, ir0, ov0, or0;
  logic [7:0] id0, od0;
  logic [1:0] oc0;
  logic [3:0] sc0;
  int errors = 0, checks = 0;
  logic [7:0] q1[$], q0[$];
  logic [7:0] n1, n0;
  logic [31:0] exp_v;
  pipe_stage_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .SKID(1), .CNT_W(3)) d1 (
    .clk(clk), .reset(rs1), .flush(fl1), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(oc1), .stall_cnt(sc1));
  pipe_stage_reg #(.WIDTH(8), .RESET_VAL(8'h3C), .SKID(0), .CNT_W(4)) d0 (
    .clk(clk), .reset(rs0), .flush(fl0), .in_valid(iv0), .in_ready(ir0), .in_data(id0),
    .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(oc0), .stall_cnt(sc0));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rs1 = 1; fl1 = 0; iv1 = 0; or1 = 1; id1 = 0;
    rs0 = 1; fl0 = 0; iv0 = 0; or0 = 1; id0 = 0;
    tick; tick;
    rs1 = 0; rs0 = 0;
    chk("rst_ov", ov1, 0); chk("rst_od", od1, 8'hA5); chk("rst_occ", oc1, 0);
    chk("rst_sc", sc1, 0); chk("rst_ir", ir1, 1);
    chk("rst0_od", od0, 8'h3C); chk("rst0_ir", ir0, 1);
    // streaming at full rate
    iv1 = 1;
    for (int i = 1; i <= 4; i++) begin
      id1 = 8'(i);
      tick;
      chk("str_ov", ov1, 1); chk("str_od", od1, i); chk("str_occ", oc1, 1); chk("str_ir", ir1, 1);
    end
    iv1 = 0; tick;
    chk("str_end_ov", ov1, 0); chk("str_sc", sc1, 0);
    // skid back-pressure A,B,C
    or1 = 0; iv1 = 1; id1 = 8'hA1; tick;
    chk("bp_a", od1, 8'hA1); chk("bp_a_ir", ir1, 1);
    id1 = 8'hB2; tick;
    chk("bp_occ2", oc1, 2); chk("bp_ir0", ir1, 0); chk("bp_hold_a", od1, 8'hA1); chk("bp_sc1", sc1, 1);
    id1 = 8'hC3; tick;
    chk("bp_occ2b", oc1, 2); chk("bp_hold_a2", od1, 8'hA1); chk("bp_sc2", sc1, 2);
    or1 = 1; tick;
    chk("bp_b", od1, 8'hB2); chk("bp_ir1", ir1, 1); chk("bp_occ1", oc1, 1);
    tick;
    chk("bp_c", od1, 8'hC3); chk("bp_c_ov", ov1, 1);
    iv1 = 0; tick;
    chk("bp_empty", ov1, 0); chk("bp_sc_keep", sc1, 2);
    // flush with both entries full
    or1 = 0; iv1 = 1; id1 = 8'h11; tick;
    id1 = 8'h22; tick;
    chk("fl_occ2", oc1, 2);
    fl1 = 1; id1 = 8'hDD; tick;
    fl1 = 0; iv1 = 0;
    chk("fl_ov", ov1, 0); chk("fl_occ", oc1, 0); chk("fl_ir", ir1, 1); chk("fl_sc", sc1, 4);
    fl1 = 1; iv1 = 1; id1 = 8'hEE; tick;
    fl1 = 0; iv1 = 0;
    chk("fl_discard", ov1, 0);
    tick;
    chk("fl_discard2", ov1, 0);
    // stall counter saturation
    rs1 = 1; tick; rs1 = 0;
    chk("sat_rst", sc1, 0);
    iv1 = 1; id1 = 8'h55; tick; iv1 = 0;
    for (int k = 1; k <= 10; k++) begin
      tick;
      chk("sat_cnt", sc1, (k > 7) ? 7 : k);
    end
    fl1 = 1; tick; fl1 = 0;
    chk("sat_flush", sc1, 7); chk("sat_flush_ov", ov1, 0);
    rs1 = 1; tick; rs1 = 0;
    chk("sat_reset", sc1, 0);
    // reset mid-operation with flush also asserted
    iv1 = 1; id1 = 8'h61; tick;
    id1 = 8'h62; tick;
    iv1 = 0; tick; tick; tick; tick;
    chk("mid_occ", oc1, 2); chk("mid_sc", sc1, 5);
    rs1 = 1; fl1 = 1; iv1 = 1; or1 = 1; id1 = 8'h77; tick;
    rs1 = 0; fl1 = 0; iv1 = 0;
    chk("mid_ov", ov1, 0); chk("mid_od", od1, 8'hA5); chk("mid_occ0", oc1, 0);
    chk("mid_sc0", sc1, 0); chk("mid_ir", ir1, 1);
    // SKID=0 back-pressure
    or0 = 0; iv0 = 1; id0 = 8'hA1; #1;
    chk("s0_ir_empty", ir0, 1);
    tick;
    chk("s0_a", od0, 8'hA1); chk("s0_ir0", ir0, 0); chk("s0_occ", oc0, 1);
    id0 = 8'hB2; tick;
    chk("s0_hold", od0, 8'hA1); chk("s0_occ1", oc0, 1); chk("s0_ir0b", ir0, 0);
    or0 = 1; #1;
    chk("s0_ir_comb", ir0, 1);
    tick;
    chk("s0_b", od0, 8'hB2);
    id0 = 8'hC3; tick;
    chk("s0_c", od0, 8'hC3); chk("s0_occ_c", oc0, 1);
    iv0 = 0; tick;
    chk("s0_empty", ov0, 0); chk("s0_sc", sc0, 1);
    // randomised traffic against FIFO scoreboards
    n1 = 0; n0 = 0;
    for (int c = 0; c < 10000; c++) begin
      iv1 = 1'($urandom_range(0, 1)); or1 = 1'($urandom_range(0, 1)); id1 = n1;
      iv0 = 1'($urandom_range(0, 1)); or0 = 1'($urandom_range(0, 1)); id0 = n0;
      #1;
      if (ov1 && or1) begin
        exp_v = (q1.size() != 0) ? 32'(q1.pop_front()) : 32'hDEAD;
        chk("rnd1_data", od1, exp_v);
      end
      if (iv1 && ir1) begin q1.push_back(id1); n1++; end
      if (ov0 && or0) begin
        exp_v = (q0.size() != 0) ? 32'(q0.pop_front()) : 32'hDEAD;
        chk("rnd0_data", od0, exp_v);
      end
      if (iv0 && ir0) begin q0.push_back(id0); n0++; end
      tick;
      chk("rnd1_occ", oc1, q1.size());
      chk("rnd0_occ", oc0, q0.size());
    end
    iv1 = 0; or1 = 1; iv0 = 0; or0 = 1;
    tick; tick; tick;
    chk("drain1", ov1, 0); chk("drain0", ov0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic parametrised pipeline-stage register with a valid/ready handshake, a synchronous flush, and an optional two-entry skid buffer. It replaces the per-field, enable-only inter-stage registers (decode→execute and the others) with one instance carrying a packed payload. The skid buffer gives a registered `in_ready`, so back-pressure does not form a combinational path across stages. A saturating stall counter provides hazard/performance visibility.

## Interface
Parameters:
- `WIDTH`, default 64: payload width in bits (≥1).
- `RESET_VAL`, default 0: value loaded into the payload registers on reset (`WIDTH` bits).
- `SKID`, default 1: 1 selects the two-entry skid buffer with registered `in_ready`; 0 selects a single entry with combinational `in_ready`.
- `CNT_W`, default 16: stall counter width (≥1).

Ports:
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: kills all held entries (branch redirect / exception).
- `in_valid` in 1: upstream has a payload.
- `in_ready` out 1: the stage accepts a payload this cycle.
- `in_data` in WIDTH: upstream payload.
- `out_valid` out 1: the stage holds a payload for downstream.
- `out_ready` in 1: downstream accepts the payload this cycle.
- `out_data` out WIDTH: payload to downstream.
- `occupancy` out 2: number of held entries (0..2; never exceeds 1 when SKID=0).
- `stall_cnt` out CNT_W: saturating count of stalled cycles.

## Operation
- Transfers:
  - Accept = `in_valid & in_ready`.
  - Emit = `out_valid & out_ready`.
- Storage: a main entry (`main_v`, `main_d`) drives `out_valid`/`out_data` directly. With SKID=1 there is also a skid entry (`skid_v`, `skid_d`).
- `in_ready`:
  - SKID=1: `in_ready = !skid_v`. It is a pure register output with no combinational dependence on `out_ready`.
  - SKID=0: `in_ready = !main_v | out_ready`.
- Update rules, SKID=1, no flush:
  - `skid_v & out_ready`: main ← skid; skid cleared. No accept is possible, because `in_ready` is 0.
  - Accept and (`!main_v` or `out_ready`): main ← `in_data`.
  - Accept and `main_v & !out_ready`: skid ← `in_data`.
  - Emit without accept: main cleared.
- Update rules, SKID=0: on accept, main ← `in_data`; on emit without accept, main cleared.
- Ordering: payloads leave in strict arrival order. No payload is lost or duplicated.
- Flush (priority over all update rules):
  - Next cycle `main_v = skid_v = 0`.
  - An input accepted in the flush cycle is discarded. Upstream sees it as consumed.
  - An emit in the flush cycle counts as completed to downstream.
  - Payload registers are not required to change on flush. `out_data` is don't-care while `out_valid = 0`.
- Payload registers load only on the data moves above, so no toggling occurs while idle.
- `occupancy = main_v + skid_v`.
- `stall_cnt`:
  - Increments by 1 in each cycle with `out_valid & !out_ready`.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset; flush does not clear it.

## Timing
- Reset values:
  - `out_valid` = 0; `out_data` = RESET_VAL; `occupancy` = 0; `stall_cnt` = 0.
  - `in_ready` = 1 (both modes).
  - Skid payload = RESET_VAL.
- Latency is 1 cycle: a payload accepted at edge N is visible on `out_data` with `out_valid = 1` after edge N.
- Throughput is 1 payload per cycle while `out_ready` stays high.
- SKID=1 back-pressure:
  - `out_ready` falls at edge N while `in_valid` is high: one more payload is absorbed into skid and `in_ready` drops after that edge.
  - `out_ready` rises again: the skid drains into main at that edge and `in_ready` returns to 1 after it.
- Reset asserted mid-operation: all state returns to its reset values at the next edge regardless of `flush`, `in_valid`, or `out_ready`.
- Simultaneous `flush` and `reset`: reset wins, including clearing `stall_cnt`.

## Test plan
- Reset, then stream payloads 1,2,3,4 with `out_ready` = 1 on consecutive cycles → each appears on `out_data` one cycle after accept, back to back; `in_ready` stays 1; `occupancy` = 1 throughout.
- SKID=1: hold `out_ready` = 0 while presenting A, B, C → A in main, B in skid, `in_ready` = 0 and C held upstream, `occupancy` = 2. Release `out_ready` → output order A, B, C with no gaps.
- SKID=0, same stimulus as the previous scenario → `in_ready` = 0 combinationally in the cycles where `main_v = 1` and `out_ready = 0`; order A, B, C; `occupancy` never exceeds 1.
- Fill both entries, then assert `flush` for one cycle while `in_valid` = 1 with D → next cycle `out_valid` = 0, `occupancy` = 0, `in_ready` = 1; D never appears at the output.
- CNT_W=3: hold `out_valid` = 1 with `out_ready` = 0 for 10 cycles → `stall_cnt` reads 1..7 and then stays at 7. Apply a flush → count unchanged. Apply reset → 0.
- Assert reset while `occupancy` = 2 and `stall_cnt` = 5 → next cycle all outputs at reset values and `out_data` = RESET_VAL. Randomised `in_valid`/`out_ready` for 10k cycles against a FIFO scoreboard → no loss, duplication, or reordering.
